// File: rtl/cfu_simd_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : cfu_simd_mac_if
// Brief    : CFU command/response bus between the CPU (master) and the unit.
// Revision : 1.0
// ============================================================================
interface cfu_simd_mac_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface
`default_nettype wire

// File: rtl/cfu_simd_mac.sv
`default_nettype none
// ============================================================================
// Module   : cfu_simd_mac
// Brief    : SIMD signed MAC CFU with input offset, wide accumulator and FSM.
// Revision : 1.0
// ============================================================================
module cfu_simd_mac #(
    parameter int LANE_W      = 8,
    parameter int ACC_W       = 32,
    parameter int MAC_LATENCY = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cfu_simd_mac_if.slave      bus
);
    localparam int         c_LANES   = 32 / LANE_W;
    localparam int         c_AOFF_W  = LANE_W + 2;
    localparam int         c_PROD_W  = 2 * LANE_W + 2;
    localparam logic [2:0] c_LAT     = 3'(MAC_LATENCY);

    localparam logic [2:0] c_OP_RESET_ACC  = 3'd0;
    localparam logic [2:0] c_OP_SET_OFFSET = 3'd1;
    localparam logic [2:0] c_OP_MAC        = 3'd2;
    localparam logic [2:0] c_OP_READ_ACC   = 3'd3;
    localparam logic [2:0] c_OP_LOAD_ACC   = 3'd4;
    localparam logic [2:0] c_OP_STATUS     = 3'd5;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

    state_t                    state_q;
    logic [2:0]                cnt_q;
    logic [31:0]               a_q, b_q;
    logic [4:0]                func_q;
    logic                      cmd_ready_q, rsp_valid_q;
    logic [31:0]               rsp_data_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [LANE_W:0]    offset_q, offset_d;
    logic                      err_q, err_d;
    logic [31:0]               result_d;

    logic [31:0]               w_in_a, w_in_b;
    logic [4:0]                w_func;
    logic                      w_accept, w_defer, w_commit;
    logic signed [31:0]        w_ld_val;
    logic signed [ACC_W-1:0]   w_sum, w_acc_shr;
    logic signed [c_PROD_W-1:0] w_prod [c_LANES];

    // Operands come straight from the bus at accept, from the capture regs while BUSY.
    assign w_in_a   = (state_q == S_IDLE) ? bus.cmd_payload_inputs_0 : a_q;
    assign w_in_b   = (state_q == S_IDLE) ? bus.cmd_payload_inputs_1 : b_q;
    assign w_func   = (state_q == S_IDLE) ? bus.cmd_payload_function_id[4:0] : func_q;
    assign w_accept = bus.cmd_valid && cmd_ready_q;
    assign w_defer  = (w_func[2:0] == c_OP_MAC) && (MAC_LATENCY != 0);
    assign w_commit = ((state_q == S_IDLE) && w_accept && !w_defer) ||
                      ((state_q == S_BUSY) && (cnt_q <= 3'd1));
    assign w_ld_val = w_in_a;

    generate
        for (genvar g = 0; g < c_LANES; g++) begin : g_lane
            logic signed [LANE_W-1:0]   w_la, w_lb;
            logic signed [c_AOFF_W-1:0] w_aoff;
            assign w_la      = w_in_a[g*LANE_W +: LANE_W];
            assign w_lb      = w_in_b[g*LANE_W +: LANE_W];
            assign w_aoff    = c_AOFF_W'(w_la) + c_AOFF_W'(offset_q);
            assign w_prod[g] = c_PROD_W'(w_aoff) * c_PROD_W'(w_lb);
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_LANES; i++) begin
            w_sum = w_sum + ACC_W'(w_prod[i]);
        end
    end

    // Upper-word read: for a 32-bit accumulator this degenerates to pure sign fill.
    assign w_acc_shr = (ACC_W > 32) ? (acc_q >>> 32) : (acc_q >>> 31);

    always_comb begin
        acc_d    = acc_q;
        offset_d = offset_q;
        err_d    = err_q;
        result_d = '0;
        case (w_func[2:0])
            c_OP_RESET_ACC:  acc_d = '0;
            c_OP_SET_OFFSET: offset_d = w_in_a[LANE_W:0];
            c_OP_MAC: begin
                acc_d    = acc_q + w_sum;
                result_d = acc_d[31:0];
            end
            c_OP_READ_ACC: begin
                result_d = w_func[4] ? w_acc_shr[31:0] : acc_q[31:0];
                if (w_func[3]) acc_d = '0;
            end
            c_OP_LOAD_ACC:   acc_d = ACC_W'(w_ld_val);
            c_OP_STATUS: begin
                result_d = {30'b0, (offset_q != '0), err_q};
                err_d    = 1'b0;
            end
            default:         err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            func_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        a_q         <= bus.cmd_payload_inputs_0;
                        b_q         <= bus.cmd_payload_inputs_1;
                        func_q      <= bus.cmd_payload_function_id[4:0];
                        cmd_ready_q <= 1'b0;
                        if (w_defer) begin
                            state_q <= S_BUSY;
                            cnt_q   <= c_LAT;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q <= 3'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Architectural state moves only on commit, so a stalled response cannot replay it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            offset_q   <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else if (w_commit) begin
            acc_q      <= acc_d;
            offset_q   <= offset_d;
            err_q      <= err_d;
            rsp_data_q <= result_d;
        end
    end

    assign bus.cmd_ready             = cmd_ready_q;
    assign bus.rsp_valid             = rsp_valid_q;
    assign bus.rsp_payload_outputs_0 = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cfu_simd_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfu_simd_mac
// Brief    : Directed bench for cfu_simd_mac (8-bit/lat-2 and 16-bit/lat-0 builds).
// Revision : 1.0
// ============================================================================
module tb_cfu_simd_mac;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cfu_simd_mac_if bus0 ();
    cfu_simd_mac_if bus1 ();

    cfu_simd_mac #(.LANE_W(8), .ACC_W(32), .MAC_LATENCY(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    cfu_simd_mac #(.LANE_W(16), .ACC_W(32), .MAC_LATENCY(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command on bus0 (called #1 after a posedge with the unit idle).
    task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bus0.cmd_payload_function_id = f;
        bus0.cmd_payload_inputs_0    = a;
        bus0.cmd_payload_inputs_1    = b;
        bus0.cmd_valid               = 1'b1;
        bus0.rsp_ready               = 1'b1;
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        lat = 1;
        while (!bus0.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus0.rsp_valid) chk("rsp_timeout", {31'b0, bus0.rsp_valid}, 32'd1);
        res = bus0.rsp_payload_outputs_0;
        @(posedge clk); #1;
    endtask

    task automatic op(input string tag, input logic [9:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] r;
        int          l;
        do_cmd(f, a, b, r, l);
        chk(tag, r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, hold;
        int          l;
        logic        seen;

        bus0.cmd_valid = 1'b0; bus0.rsp_ready = 1'b1; bus0.cmd_payload_function_id = '0;
        bus0.cmd_payload_inputs_0 = '0; bus0.cmd_payload_inputs_1 = '0;
        bus1.cmd_valid = 1'b0; bus1.rsp_ready = 1'b1; bus1.cmd_payload_function_id = '0;
        bus1.cmd_payload_inputs_0 = '0; bus1.cmd_payload_inputs_1 = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);
        chk("rst_payload",   bus0.rsp_payload_outputs_0, 32'd0);
        chk("rst_cmd_ready", {31'b0, bus0.cmd_ready}, 32'd1);

        // Defaults: offset 128, four small lanes
        op("set_off128", 10'd1, 32'd128, 32'd0, 32'd0);
        do_cmd(10'd2, 32'h01020304, 32'h01010101, r, l);
        chk("mac1_data", r, 32'h0000020A);
        chk("mac1_lat", 32'(l), 32'd3);
        op("read1", 10'd3, 32'd0, 32'd0, 32'h0000020A);
        op("status_offnz", 10'd5, 32'd0, 32'd0, 32'h00000002);

        // Negative lanes, high-word read, read-and-clear
        op("reset_acc", 10'd0, 32'd0, 32'd0, 32'd0);
        op("set_off0", 10'd1, 32'd0, 32'd0, 32'd0);
        op("mac_neg", 10'd2, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFF8);
        op("read_hi", 10'h013, 32'd0, 32'd0, 32'hFFFFFFFF);
        op("read_clr", 10'h00B, 32'd0, 32'd0, 32'hFFFFFFF8);
        op("read_after_clr", 10'd3, 32'd0, 32'd0, 32'd0);

        // Wrap modulo 2^32
        op("load_acc", 10'd4, 32'h7FFFFFFF, 32'd0, 32'd0);
        op("mac_wrap", 10'd2, 32'h00000001, 32'h00000001, 32'h80000000);

        // Back-pressure: response held, no new command accepted
        op("reset_acc2", 10'd0, 32'd0, 32'd0, 32'd0);
        bus0.cmd_payload_function_id = 10'd2;
        bus0.cmd_payload_inputs_0    = 32'h05050505;
        bus0.cmd_payload_inputs_1    = 32'h01010101;
        bus0.cmd_valid               = 1'b1;
        bus0.rsp_ready               = 1'b0;
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        l = 1;
        while (!bus0.rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        chk("bp_lat", 32'(l), 32'd3);
        hold = bus0.rsp_payload_outputs_0;
        chk("bp_data", hold, 32'h00000014);
        for (int k = 0; k < 3; k++) begin
            bus0.cmd_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_stable", bus0.rsp_payload_outputs_0, 32'h00000014);
            chk("bp_valid", {31'b0, bus0.rsp_valid}, 32'd1);
            chk("bp_cmd_ready", {31'b0, bus0.cmd_ready}, 32'd0);
        end
        bus0.cmd_valid = 1'b0;
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", {31'b0, bus0.rsp_valid}, 32'd0);
        op("bp_single_acc", 10'd3, 32'd0, 32'd0, 32'h00000014);

        // Illegal op sets sticky err, STATUS clears it
        op("illegal", 10'd7, 32'h12345678, 32'h9ABCDEF0, 32'd0);
        op("status_err", 10'd5, 32'd0, 32'd0, 32'h00000001);
        op("status_clr", 10'd5, 32'd0, 32'd0, 32'h00000000);

        // Reset during BUSY discards the op
        bus0.cmd_payload_function_id = 10'd2;
        bus0.cmd_payload_inputs_0    = 32'h01010101;
        bus0.cmd_payload_inputs_1    = 32'h01010101;
        bus0.cmd_valid               = 1'b1;
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_cmd_ready", {31'b0, bus0.cmd_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen |= bus0.rsp_valid;
            @(posedge clk); #1;
        end
        chk("midrst_no_rsp", {31'b0, seen}, 32'd0);
        op("midrst_acc", 10'd3, 32'd0, 32'd0, 32'd0);

        // 16-bit lanes, zero extra latency
        bus1.cmd_payload_function_id = 10'd2;
        bus1.cmd_payload_inputs_0    = 32'h0003FFFE;
        bus1.cmd_payload_inputs_1    = 32'h00050007;
        bus1.cmd_valid               = 1'b1;
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        chk("l16_rsp_t1", {31'b0, bus1.rsp_valid}, 32'd1);
        chk("l16_data", bus1.rsp_payload_outputs_0, 32'h00000001);
        @(posedge clk); #1;
        bus1.cmd_payload_inputs_0 = 32'h80000001;
        bus1.cmd_payload_inputs_1 = 32'h00020003;
        bus1.cmd_valid            = 1'b1;
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        chk("l16_rsp2_t1", {31'b0, bus1.rsp_valid}, 32'd1);
        chk("l16_data2", bus1.rsp_payload_outputs_0, 32'hFFFF0004);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
